// File: rtl/sha1_w_sched_if.sv
// Bundles the message-word handshake and the round-control outputs of the SHA-1
// message schedule. The slave modport is the scheduler; the master modport is the
// word source together with the round datapath.
interface sha1_w_sched_if;
  logic        in_valid;
  logic [31:0] in_data;
  logic        in_ready;
  logic        hold;
  logic        feed;
  logic        next;
  logic [31:0] w;
  logic [6:0]  round;
  logic [1:0]  seg;
  logic        busy;
  logic        done;

  modport slave (
    input  in_valid, in_data, hold,
    output in_ready, feed, next, w, round, seg, busy, done
  );

  modport master (
    output in_valid, in_data, hold,
    input  in_ready, feed, next, w, round, seg, busy, done
  );
endinterface

// File: rtl/sha1_w_sched.sv
// SHA-1 message schedule: takes one 16-word block, then issues W[0..79] in place
// through a 16-entry circular buffer while pacing the round datapath.
//
// state  | meaning
// S_LOAD | accept 16 message words into r_buf[0..15]
// S_FEED | one cycle, tell the round registers to load chaining values
// S_RUN  | issue one round per un-held cycle, t = 0..79
// S_DONE | one cycle completion pulse, then back to S_LOAD
module sha1_w_sched (
  input  logic            clk,
  input  logic            reset,
  sha1_w_sched_if.slave   bus
);

  typedef enum logic [1:0] {S_LOAD, S_FEED, S_RUN, S_DONE} state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [31:0] r_buf [16];
  logic [3:0]  r_lcnt;
  logic [6:0]  r_t;

  logic        w_in_ready;
  logic        w_feed;
  logic        w_next;
  logic        w_busy;
  logic        w_done;
  logic [31:0] w_sched;
  logic [31:0] w_mix;
  logic [3:0]  w_t4;
  logic [3:0]  w_i3;
  logic [3:0]  w_i8;
  logic [3:0]  w_i14;
  logic [1:0]  w_seg;

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_LOAD;
    else       r_state <= w_state_nxt;
  end

  // Outputs are gated by reset so a reset cycle is quiet regardless of state.
  always_comb begin
    w_state_nxt = r_state;
    w_in_ready  = 1'b0;
    w_feed      = 1'b0;
    w_next      = 1'b0;
    w_busy      = 1'b0;
    w_done      = 1'b0;
    unique case (r_state)
      S_LOAD: begin
        w_in_ready = 1'b1;
        if (bus.in_valid && (r_lcnt == 4'd15)) w_state_nxt = S_FEED;
      end
      S_FEED: begin
        w_feed      = 1'b1;
        w_busy      = 1'b1;
        w_state_nxt = S_RUN;
      end
      S_RUN: begin
        w_busy = 1'b1;
        w_next = ~bus.hold;
        if (w_next && (r_t == 7'd79)) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        w_done      = 1'b1;
        w_state_nxt = S_LOAD;
      end
      default: w_state_nxt = S_LOAD;
    endcase
    if (reset) begin
      w_in_ready = 1'b0;
      w_feed     = 1'b0;
      w_next     = 1'b0;
      w_busy     = 1'b0;
      w_done     = 1'b0;
    end
  end

  // Schedule word: all buffer indices wrap modulo 16.
  assign w_t4    = r_t[3:0];
  assign w_i3    = w_t4 - 4'd3;
  assign w_i8    = w_t4 - 4'd8;
  assign w_i14   = w_t4 - 4'd14;
  assign w_mix   = r_buf[w_i3] ^ r_buf[w_i8] ^ r_buf[w_i14] ^ r_buf[w_t4];
  assign w_sched = (r_t < 7'd16) ? r_buf[w_t4] : {w_mix[30:0], w_mix[31]};

  always_comb begin
    if (r_t < 7'd20)      w_seg = 2'd0;
    else if (r_t < 7'd40) w_seg = 2'd1;
    else if (r_t < 7'd60) w_seg = 2'd2;
    else                  w_seg = 2'd3;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_lcnt <= 4'd0;
      r_t    <= 7'd0;
    end else begin
      if (w_in_ready && bus.in_valid) r_lcnt <= r_lcnt + 4'd1;
      if (w_feed) r_t <= 7'd0;
      else if (w_next && (r_t != 7'd79)) r_t <= r_t + 7'd1;
    end
  end

  // Buffer needs no reset; writes are already suppressed by the gated strobes.
  always_ff @(posedge clk) begin
    if (w_in_ready && bus.in_valid) r_buf[r_lcnt] <= bus.in_data;
    else if (w_next && (r_t >= 7'd16)) r_buf[w_t4] <= w_sched;
  end

  assign bus.in_ready = w_in_ready;
  assign bus.feed     = w_feed;
  assign bus.next     = w_next;
  assign bus.busy     = w_busy;
  assign bus.done     = w_done;
  assign bus.w        = w_sched;
  assign bus.round    = r_t;
  assign bus.seg      = w_seg;

endmodule

// File: tb/tb_sha1_w_sched.sv
// Bench for sha1_w_sched: the expected W sequence comes from the textbook 80-word
// SHA-1 expansion over a plain array, compared round by round with the DUT.
module tb_sha1_w_sched;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  sha1_w_sched_if bus ();

  sha1_w_sched dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  int vectors = 0;
  int errors  = 0;
  logic [31:0] m_blk [16];
  logic [31:0] m_w   [80];

  function automatic logic [31:0] rotl1(logic [31:0] x);
    return {x[30:0], x[31]};
  endfunction

  function automatic void build_ref();
    for (int t = 0; t < 16; t++) m_w[t] = m_blk[t];
    for (int t = 16; t < 80; t++)
      m_w[t] = rotl1(m_w[t-3] ^ m_w[t-8] ^ m_w[t-14] ^ m_w[t-16]);
  endfunction

  function automatic logic [31:0] exp_seg(int t);
    return 32'(t / 20);
  endfunction

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic drive(logic v, logic [31:0] d, logic h, logic r);
    @(negedge clk);
    bus.in_valid = v;
    bus.in_data  = d;
    bus.hold     = h;
    reset        = r;
    #1;
  endtask

  task automatic abc_block();
    for (int i = 0; i < 16; i++) m_blk[i] = 32'h0;
    m_blk[0]  = 32'h61626380;
    m_blk[15] = 32'h00000018;
    build_ref();
  endtask

  task automatic rand_block();
    for (int i = 0; i < 16; i++) m_blk[i] = $urandom;
    build_ref();
  endtask

  task automatic load_block(bit toggle);
    int   i = 0;
    int   guard = 0;
    logic v;
    while (i < 16 && guard < 100) begin
      v = toggle ? logic'(guard[0]) : 1'b1;
      drive(v, v ? m_blk[i] : $urandom, 1'($urandom_range(0, 1)), 1'b0);
      chk("load_ready", 32'(bus.in_ready), 32'd1);
      chk("load_feed",  32'(bus.feed),     32'd0);
      chk("load_busy",  32'(bus.busy),     32'd0);
      chk("load_done",  32'(bus.done),     32'd0);
      if (v) i++;
      guard++;
    end
    if (i < 16) chk("load_timeout", 32'(i), 32'd16);
  endtask

  // hold_mode: 0 none, 1 three cycles at t=16, 2 random. abort_t<0 runs to completion.
  task automatic run_block(int hold_mode, int abort_t, bit abc, bit flood);
    int   t = 0;
    int   cyc = 0;
    int   h3 = 0;
    int   pulses = 0;
    logic h;
    drive(flood, $urandom, 1'($urandom_range(0, 1)), 1'b0);
    chk("feed_pulse", 32'(bus.feed),     32'd1);
    chk("feed_next",  32'(bus.next),     32'd0);
    chk("feed_busy",  32'(bus.busy),     32'd1);
    chk("feed_ready", 32'(bus.in_ready), 32'd0);
    while (t < 80 && cyc < 400) begin
      if (t == abort_t) begin
        drive(1'b1, $urandom, 1'b0, 1'b1);
        chk("rst_next",  32'(bus.next),     32'd0);
        chk("rst_busy",  32'(bus.busy),     32'd0);
        chk("rst_ready", 32'(bus.in_ready), 32'd0);
        chk("rst_feed",  32'(bus.feed),     32'd0);
        chk("rst_done",  32'(bus.done),     32'd0);
        return;
      end
      if (hold_mode == 1)      h = (t == 16) && (h3 < 3);
      else if (hold_mode == 2) h = ($urandom_range(0, 3) == 0);
      else                     h = 1'b0;
      if (h && hold_mode == 1) h3++;
      drive(flood, $urandom, h, 1'b0);
      chk("run_round", 32'(bus.round), 32'(t));
      chk("run_w",     bus.w,          m_w[t]);
      chk("run_seg",   32'(bus.seg),   exp_seg(t));
      chk("run_busy",  32'(bus.busy),  32'd1);
      chk("run_feed",  32'(bus.feed),  32'd0);
      chk("run_next",  32'(bus.next),  32'(!h));
      chk("run_ready", 32'(bus.in_ready), 32'd0);
      if (abc && t == 16) chk("abc_w16", bus.w, 32'hC2C4C700);
      if (abc && t == 17) chk("abc_w17", bus.w, 32'h00000000);
      if (abc && t == 18) chk("abc_w18", bus.w, 32'h00000030);
      if (!h) begin
        t++;
        pulses++;
      end
      cyc++;
    end
    chk("next_pulses", 32'(pulses), 32'd80);
    if (hold_mode == 0) chk("run_cycles", 32'(cyc), 32'd80);
    if (hold_mode == 1) chk("run_cycles_hold", 32'(cyc), 32'd83);
    drive(flood, $urandom, 1'($urandom_range(0, 1)), 1'b0);
    chk("done_pulse", 32'(bus.done),     32'd1);
    chk("done_next",  32'(bus.next),     32'd0);
    chk("done_busy",  32'(bus.busy),     32'd0);
    chk("done_feed",  32'(bus.feed),     32'd0);
    chk("done_ready", 32'(bus.in_ready), 32'd0);
  endtask

  initial begin
    reset        = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_data  = 32'h0;
    bus.hold     = 1'b0;

    drive(1'b1, 32'hDEADBEEF, 1'b0, 1'b1);
    drive(1'b1, 32'hDEADBEEF, 1'b0, 1'b1);
    chk("reset_ready", 32'(bus.in_ready), 32'd0);
    chk("reset_busy",  32'(bus.busy),     32'd0);
    chk("reset_feed",  32'(bus.feed),     32'd0);
    chk("reset_next",  32'(bus.next),     32'd0);
    chk("reset_done",  32'(bus.done),     32'd0);
    chk("reset_round", 32'(bus.round),    32'd0);

    // "abc" block: toggled load, in_valid held high through the run, no stalls
    abc_block();
    load_block(1'b1);
    run_block(0, -1, 1'b1, 1'b1);

    // "abc" block with a three-cycle stall at t=16
    load_block(1'b0);
    run_block(1, -1, 1'b1, 1'b0);

    for (int k = 0; k < 3; k++) begin
      rand_block();
      load_block(k[0]);
      run_block(2, -1, 1'b0, 1'b1);
    end

    // reset at t=40, then a fresh block must load from buf[0]
    rand_block();
    load_block(1'b0);
    run_block(0, 40, 1'b0, 1'b0);
    rand_block();
    load_block(1'b0);
    run_block(0, -1, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule

// File: doc/sha1_w_sched.md
SHA1_W_SCHED -- requirements
Module: sha1_w_sched

Interface
REQ-001 SHALL have port clk, input, 1 bit, sole clock; all state updates on rising edge.
REQ-002 SHALL have port reset, input, 1 bit, synchronous active-high reset sampled on rising clk.
REQ-003 SHALL have port in_valid, input, 1 bit, a message word is offered on in_data.
REQ-004 SHALL have port in_data, input, 32 bits, message word, big-endian word order W0 first.
REQ-005 SHALL have port in_ready, output, 1 bit, block accepts a word this cycle.
REQ-006 SHALL have port hold, input, 1 bit, stall request from the round datapath.
REQ-007 SHALL have port feed, output, 1 bit, one-cycle pulse loading chaining values into the round registers.
REQ-008 SHALL have port next, output, 1 bit, advance the round registers by one round using w.
REQ-009 SHALL have port w, output, 32 bits, schedule word W[t] for the current round.
REQ-010 SHALL have port round, output, 7 bits, current round index t, 0..79.
REQ-011 SHALL have port seg, output, 2 bits, round-function group: 0 for t 0..19, 1 for 20..39, 2 for 40..59, 3 for 60..79.
REQ-012 SHALL have port busy, output, 1 bit, high in FEED and RUN.
REQ-013 SHALL have port done, output, 1 bit, one-cycle pulse after round 79 is issued.

Function
REQ-014 SHALL implement states LOAD, FEED, RUN, DONE with a 16-entry x 32-bit circular buffer buf, a 4-bit load counter lcnt, and a 7-bit round counter t.
REQ-015 LOAD: in_ready=1; on in_valid&in_ready, buf[lcnt]<=in_data, lcnt<=lcnt+1; on the handshake with lcnt=15, go to FEED, lcnt<=0.
REQ-016 in_valid while not in LOAD SHALL be ignored (in_ready=0, no buffer write).
REQ-017 FEED: exactly one cycle, feed=1, next=0, t<=0, then RUN; hold has no effect in FEED.
REQ-018 RUN: next = ~hold; feed=0; w, round and seg driven combinationally from t and buf.
REQ-019 w for t<16 SHALL be buf[t[3:0]].
REQ-020 w for t>=16 SHALL be ROTL1(buf[(t-3)&15] ^ buf[(t-8)&15] ^ buf[(t-14)&15] ^ buf[t&15]), all index arithmetic mod 16.
REQ-021 On a RUN cycle with next=1 and t>=16, buf[t&15]<=w; with t<16, buf unchanged; t<=t+1.
REQ-022 On a RUN cycle with hold=1, t, buf and state SHALL be unchanged and w stable.
REQ-023 Advance with t=79 SHALL go to DONE; t never exceeds 79 and never wraps.
REQ-024 DONE: exactly one cycle, done=1, next=0, feed=0, then LOAD.
REQ-025 Outside RUN, next=0, and w, round, seg SHALL hold the last values of t-derived logic (t retains its value).
REQ-026 busy SHALL be 1 exactly in FEED and RUN.
REQ-027 Minimum latency: last load handshake at cycle N -> feed at N+1 -> next at N+2..N+81 with zero hold -> done at N+82; in_ready at N+83.

Reset
REQ-028 reset=1 SHALL force state LOAD, lcnt=0, t=0; outputs feed=0, next=0, done=0, busy=0, in_ready=0 during reset and 1 in the first cycle after.
REQ-029 buf contents SHALL not be required to reset; a reset mid-LOAD or mid-RUN SHALL discard the partial block and the first post-reset word SHALL land in buf[0].
REQ-030 reset SHALL take priority over every handshake and hold in the same cycle.

Verification
REQ-031 "abc" padded block (W0=0x61626380, W1..W14=0, W15=0x00000018), hold=0 -> W16=0xC2C4C700, W17=0, W18=0x00000030; 80 next pulses; done exactly 82 cycles after last handshake.
REQ-032 Same block, hold=1 for 3 cycles at t=16 -> next low 3 cycles, w stays 0xC2C4C700, round stays 16; total next pulses still 80.
REQ-033 in_valid toggled 1/0 every cycle during LOAD -> 16 words captured in order; feed only after the 16th.
REQ-034 in_valid=1 throughout RUN -> in_ready=0, no words consumed, W sequence identical to REQ-031.
REQ-035 reset asserted at t=40 -> next drops immediately, busy=0; new block reloads from buf[0] and produces its correct W16.
REQ-036 seg checked against round -> transitions 0->1 at t=20, 1->2 at t=40, 2->3 at t=60.
